// File: rtl/cpu_accel_hub.sv
// CPU-to-accelerator hub: one TX and one RX FIFO per channel, CPU side selected by accel_id.
// Optional sticky protocol-error flag enabled by defining CPU_ACCEL_HUB_ERR_EN.
module cpu_accel_hub #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [3:0]                         accel_id,
    output logic                               accel_can_read,
    output logic                               accel_can_write,
    input  logic                               accel_read_enable,
    output logic [DATA_WIDTH-1:0]              accel_read_data,
    input  logic                               accel_write_enable,
    input  logic [DATA_WIDTH-1:0]              accel_write_data,
    output logic [NUM_CHANNELS-1:0]            ch_out_valid,
    input  logic [NUM_CHANNELS-1:0]            ch_out_ready,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_out_data,
    input  logic [NUM_CHANNELS-1:0]            ch_in_valid,
    output logic [NUM_CHANNELS-1:0]            ch_in_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_in_data,
    output logic                               err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [NUM_CHANNELS-1:0] sel;
    logic [NUM_CHANNELS-1:0] tx_push, tx_pop, tx_full, tx_empty;
    logic [NUM_CHANNELS-1:0] rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_WIDTH-1:0]   tx_head [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]   rx_head [NUM_CHANNELS];

    // Ids with no matching channel select nothing, so outputs stay at their defaults.
    always_comb begin
        sel             = '0;
        accel_can_read  = 1'b0;
        accel_can_write = 1'b0;
        accel_read_data = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (accel_id == 4'(i)) begin
                sel[i]          = 1'b1;
                accel_can_read  = !rx_empty[i];
                accel_can_write = !tx_full[i];
                accel_read_data = rx_empty[i] ? '0 : rx_head[i];
            end
        end
    end

    assign tx_push      = sel & ~tx_full & {NUM_CHANNELS{accel_write_enable}};
    assign rx_pop       = sel & ~rx_empty & {NUM_CHANNELS{accel_read_enable}};
    assign tx_pop       = ch_out_ready & ~tx_empty;
    assign rx_push      = ch_in_valid & ~rx_full;
    assign ch_out_valid = ~tx_empty;
    assign ch_in_ready  = ~rx_full;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
        logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
        logic [PTR_W-1:0]      tx_wr, tx_rd, rx_wr, rx_rd;
        logic [CNT_W-1:0]      tx_cnt, rx_cnt;

        // Pointers wrap for free because FIFO_DEPTH is a power of two.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tx_wr  <= '0;
                tx_rd  <= '0;
                tx_cnt <= '0;
                rx_wr  <= '0;
                rx_rd  <= '0;
                rx_cnt <= '0;
            end else begin
                if (tx_push[g]) tx_wr <= tx_wr + 1'b1;
                if (tx_pop[g])  tx_rd <= tx_rd + 1'b1;
                if (rx_push[g]) rx_wr <= rx_wr + 1'b1;
                if (rx_pop[g])  rx_rd <= rx_rd + 1'b1;
                tx_cnt <= tx_cnt + CNT_W'(tx_push[g]) - CNT_W'(tx_pop[g]);
                rx_cnt <= rx_cnt + CNT_W'(rx_push[g]) - CNT_W'(rx_pop[g]);
            end
        end

        // NOTE: storage is not reset; the counts alone decide which words are live.
        always_ff @(posedge clk) begin
            if (tx_push[g]) tx_mem[tx_wr] <= accel_write_data;
            if (rx_push[g]) rx_mem[rx_wr] <= ch_in_data[g*DATA_WIDTH +: DATA_WIDTH];
        end

        assign tx_full[g]  = (tx_cnt == FULL_CNT);
        assign tx_empty[g] = (tx_cnt == '0);
        assign rx_full[g]  = (rx_cnt == FULL_CNT);
        assign rx_empty[g] = (rx_cnt == '0);
        assign tx_head[g]  = tx_mem[tx_rd];
        assign rx_head[g]  = rx_mem[rx_rd];
        assign ch_out_data[g*DATA_WIDTH +: DATA_WIDTH] = tx_head[g];
    end

`ifdef CPU_ACCEL_HUB_ERR_EN
    localparam logic [4:0] NUM_CH_ID = 5'(NUM_CHANNELS);
    logic id_valid;
    logic bad_access;

    assign id_valid   = ({1'b0, accel_id} < NUM_CH_ID);
    assign bad_access = (accel_read_enable && !accel_can_read)
                     || (accel_write_enable && !accel_can_write)
                     || ((accel_read_enable || accel_write_enable) && !id_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             err <= 1'b0;
        else if (bad_access) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
